// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_pkg
// Description : Core configuration and shared store types for the LSU store
//               buffer and its forwarding sub-block.
// Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    // Core configuration
    localparam int LSU_STORE_QUEUE_SIZE = 8;
    localparam int LSU_COMMIT_WIDTH     = 2;
    localparam int LSU_ADDR_WIDTH       = 32;
    localparam int LSU_DATA_WIDTH       = 32;

    // Core types: a store request at the default core widths
    typedef struct packed {
        logic [LSU_ADDR_WIDTH-1:0]   addr;
        logic [LSU_DATA_WIDTH-1:0]   data;
        logic [LSU_DATA_WIDTH/8-1:0] strb;
    } store_req_t;

    // Pointer width carrying one extra wrap bit above the index
    function automatic int sb_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fwd_merge.sv
`default_nettype none
// ============================================================================
// Module      : sb_fwd_merge
// Description : Combinational per-byte store-to-load forwarding. Walks live
//               entries from oldest to youngest so the youngest matching
//               entry with its strobe set supplies each byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = LSU_STORE_QUEUE_SIZE,
    parameter int WADDR_W    = 30,
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic [WADDR_W-1:0]         ent_waddr_i [DEPTH],
    input  logic [DATA_WIDTH-1:0]      ent_data_i  [DEPTH],
    input  logic [DATA_WIDTH/8-1:0]    ent_strb_i  [DEPTH],
    input  logic [DEPTH-1:0]           live_i,
    input  logic [$clog2(DEPTH)-1:0]   head_idx_i,
    input  logic [WADDR_W-1:0]         fwd_waddr_i,
    output logic [DATA_WIDTH-1:0]      fwd_data_o,
    output logic [DATA_WIDTH/8-1:0]    fwd_mask_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DEPTH-1:0] w_hit;
    logic [IDX_W-1:0] w_idx;

    // Word-address hit per live entry
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign w_hit[i] = live_i[i] && (ent_waddr_i[i] == fwd_waddr_i);
    end

    // Age-ordered byte merge: later (younger) hits overwrite earlier ones
    always_comb begin
        fwd_data_o = '0;
        fwd_mask_o = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = head_idx_i + IDX_W'(k);
            if (w_hit[w_idx]) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (ent_strb_i[w_idx][b]) begin
                        fwd_data_o[8*b +: 8] = ent_data_i[w_idx][8*b +: 8];
                        fwd_mask_o[b]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Circular buffer of speculative stores. Entries are pushed at
//               execute, committed in order by the ROB, discarded on flush if
//               uncommitted, and drained oldest-first to the DCache. Loads get
//               same-cycle per-byte forwarding from all live entries.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH        = LSU_STORE_QUEUE_SIZE,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int COMMIT_WIDTH = LSU_COMMIT_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push_valid_i,
    output logic                              push_ready_o,
    input  logic [ADDR_WIDTH-1:0]             push_addr_i,
    input  logic [DATA_WIDTH-1:0]             push_data_i,
    input  logic [DATA_WIDTH/8-1:0]           push_strb_i,
    input  logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_num_i,
    input  logic                              flush_i,
    output logic                              drain_valid_o,
    input  logic                              drain_ready_i,
    output logic [ADDR_WIDTH-1:0]             drain_addr_o,
    output logic [DATA_WIDTH-1:0]             drain_data_o,
    output logic [DATA_WIDTH/8-1:0]           drain_strb_o,
    input  logic [ADDR_WIDTH-1:0]             fwd_addr_i,
    output logic [DATA_WIDTH-1:0]             fwd_data_o,
    output logic [DATA_WIDTH/8-1:0]           fwd_mask_o,
    output logic                              empty_o
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = sb_ptr_width(DEPTH);
    localparam int CNUM_W  = $clog2(COMMIT_WIDTH + 1);
    localparam int CMP_W   = PTR_W + CNUM_W;
    localparam int OFS_W   = $clog2(STRB_W);
    localparam int WADDR_W = ADDR_WIDTH - OFS_W;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
    } sb_entry_t;

    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] cmt_q,  cmt_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic [PTR_W-1:0]      w_live_cnt;
    logic [PTR_W-1:0]      w_uncmt_cnt;
    logic [PTR_W-1:0]      w_cmt_amt;
    logic                  w_push_fire;
    logic                  w_drain_fire;
    logic [IDX_W-1:0]      w_head_idx;
    logic [IDX_W-1:0]      w_tail_idx;
    logic [IDX_W-1:0]      w_age [DEPTH];
    logic [DEPTH-1:0]      w_live_mask;
    logic [WADDR_W-1:0]    w_ent_waddr [DEPTH];
    logic [DATA_WIDTH-1:0] w_ent_data  [DEPTH];
    logic [STRB_W-1:0]     w_ent_strb  [DEPTH];

    assign w_live_cnt  = tail_q - head_q;
    assign w_uncmt_cnt = tail_q - cmt_q;
    assign w_head_idx  = head_q[IDX_W-1:0];
    assign w_tail_idx  = tail_q[IDX_W-1:0];

    // A full buffer never accepts, even if the head drains this same cycle
    assign push_ready_o  = (w_live_cnt < PTR_W'(DEPTH)) && !flush_i;
    assign w_push_fire   = push_valid_i && push_ready_o;
    assign drain_valid_o = (cmt_q != head_q);
    assign w_drain_fire  = drain_valid_o && drain_ready_i;
    assign empty_o       = (head_q == tail_q);

    // Over-commit saturates at the entries pushed before this cycle
    assign w_cmt_amt = (CMP_W'(commit_num_i) < CMP_W'(w_uncmt_cnt))
                     ? PTR_W'(commit_num_i) : w_uncmt_cnt;

    // Drain payload reads as zero while nothing committed is waiting
    assign drain_addr_o = drain_valid_o ? entries_q[w_head_idx].addr : '0;
    assign drain_data_o = drain_valid_o ? entries_q[w_head_idx].data : '0;
    assign drain_strb_o = drain_valid_o ? entries_q[w_head_idx].strb : '0;

    // Per-slot age relative to head decides liveness; unpack for the merger
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign w_age[i]       = IDX_W'(i) - w_head_idx;
        assign w_live_mask[i] = ({1'b0, w_age[i]} < w_live_cnt);
        assign w_ent_waddr[i] = entries_q[i].addr[ADDR_WIDTH-1:OFS_W];
        assign w_ent_data[i]  = entries_q[i].data;
        assign w_ent_strb[i]  = entries_q[i].strb;
    end

    // Byte offset of the load address does not take part in the word match
    if (OFS_W > 0) begin : g_ofs
        logic w_fwd_ofs_unused;
        assign w_fwd_ofs_unused = ^fwd_addr_i[OFS_W-1:0];
    end

    sb_fwd_merge #(
        .DEPTH      (DEPTH),
        .WADDR_W    (WADDR_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd_merge (
        .ent_waddr_i (w_ent_waddr),
        .ent_data_i  (w_ent_data),
        .ent_strb_i  (w_ent_strb),
        .live_i      (w_live_mask),
        .head_idx_i  (w_head_idx),
        .fwd_waddr_i (fwd_addr_i[ADDR_WIDTH-1:OFS_W]),
        .fwd_data_o  (fwd_data_o),
        .fwd_mask_o  (fwd_mask_o)
    );

    // Next pointers: drain, saturated commit, push; flush rewinds tail to cmt
    always_comb begin
        head_d = head_q + PTR_W'(w_drain_fire);
        cmt_d  = cmt_q + w_cmt_amt;
        tail_d = tail_q + PTR_W'(w_push_fire);
        if (flush_i) begin
            tail_d = cmt_d;
        end
    end

    // Entry write on an accepted push
    always_comb begin
        entries_d = entries_q;
        if (w_push_fire) begin
            entries_d[w_tail_idx].addr = push_addr_i;
            entries_d[w_tail_idx].data = push_data_i;
            entries_d[w_tail_idx].strb = push_strb_i;
        end
    end

    // Pointer registers; reset empties the buffer including committed stores
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage; validity comes from the pointers so no reset is needed
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer against a queue-based
//               reference model, directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid_i;
    logic        push_ready_o;
    logic [31:0] push_addr_i;
    logic [31:0] push_data_i;
    logic [3:0]  push_strb_i;
    logic [1:0]  commit_num_i;
    logic        flush_i;
    logic        drain_valid_o;
    logic        drain_ready_i;
    logic [31:0] drain_addr_o;
    logic [31:0] drain_data_o;
    logic [3:0]  drain_strb_o;
    logic [31:0] fwd_addr_i;
    logic [31:0] fwd_data_o;
    logic [3:0]  fwd_mask_o;
    logic        empty_o;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH        (DEPTH),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .COMMIT_WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid_i  (push_valid_i),
        .push_ready_o  (push_ready_o),
        .push_addr_i   (push_addr_i),
        .push_data_i   (push_data_i),
        .push_strb_i   (push_strb_i),
        .commit_num_i  (commit_num_i),
        .flush_i       (flush_i),
        .drain_valid_o (drain_valid_o),
        .drain_ready_i (drain_ready_i),
        .drain_addr_o  (drain_addr_o),
        .drain_data_o  (drain_data_o),
        .drain_strb_o  (drain_strb_o),
        .fwd_addr_i    (fwd_addr_i),
        .fwd_data_o    (fwd_data_o),
        .fwd_mask_o    (fwd_mask_o),
        .empty_o       (empty_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    // Reference model: program-ordered queue, oldest mcmt entries committed
    ent_t mq[$];
    int   mcmt;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_fwd(input logic [31:0] a, output logic [31:0] d, output logic [3:0] m);
        d = '0;
        m = '0;
        foreach (mq[k]) begin
            if (mq[k].addr[31:2] == a[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mq[k].strb[b]) begin
                        d[8*b +: 8] = mq[k].data[8*b +: 8];
                        m[b]        = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        logic [31:0] ed;
        logic [3:0]  em;
        check_eq("push_ready", push_ready_o, (mq.size() < DEPTH) && !flush_i);
        check_eq("empty", empty_o, mq.size() == 0);
        check_eq("drain_valid", drain_valid_o, mcmt > 0);
        if (mcmt > 0) begin
            check_eq("drain_addr", drain_addr_o, mq[0].addr);
            check_eq("drain_data", drain_data_o, mq[0].data);
            check_eq("drain_strb", drain_strb_o, mq[0].strb);
        end
        model_fwd(fwd_addr_i, ed, em);
        check_eq("fwd_data", fwd_data_o, ed);
        check_eq("fwd_mask", fwd_mask_o, em);
    endtask

    task automatic model_update();
        int unc;
        int amt;
        bit pf;
        bit df;
        unc = mq.size() - mcmt;
        amt = (int'(commit_num_i) < unc) ? int'(commit_num_i) : unc;
        pf  = push_valid_i && (mq.size() < DEPTH) && !flush_i;
        df  = drain_ready_i && (mcmt > 0);
        if (df) begin
            void'(mq.pop_front());
            mcmt--;
        end
        mcmt += amt;
        if (flush_i) begin
            while (mq.size() > mcmt) void'(mq.pop_back());
        end
        if (pf) mq.push_back('{push_addr_i, push_data_i, push_strb_i});
    endtask

    task automatic drive(input bit pv, input logic [31:0] pa, input logic [31:0] pd,
                         input logic [3:0] ps, input int cn, input bit fl,
                         input bit dr, input logic [31:0] fa);
        @(negedge clk);
        push_valid_i  = pv;
        push_addr_i   = pa;
        push_data_i   = pd;
        push_strb_i   = ps;
        commit_num_i  = 2'(cn);
        flush_i       = fl;
        drain_ready_i = dr;
        fwd_addr_i    = fa;
        #1;
        model_check();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
    endtask

    task automatic step(input bit pv, input logic [31:0] pa, input logic [31:0] pd,
                        input logic [3:0] ps, input int cn, input bit fl,
                        input bit dr, input logic [31:0] fa);
        drive(pv, pa, pd, ps, cn, fl, dr, fa);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        push_valid_i  = 1'b0;
        commit_num_i  = '0;
        flush_i       = 1'b0;
        drain_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        mq.delete();
        mcmt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; push_valid_i = 0; push_addr_i = 0; push_data_i = 0; push_strb_i = 0;
        commit_num_i = 0; flush_i = 0; drain_ready_i = 0; fwd_addr_i = 0;
        mcmt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_push_ready", push_ready_o, 1);
        check_eq("rst_drain_valid", drain_valid_o, 0);
        check_eq("rst_drain_addr", drain_addr_o, 0);
        check_eq("rst_drain_data", drain_data_o, 0);
        check_eq("rst_drain_strb", drain_strb_o, 0);
        check_eq("rst_fwd_mask", fwd_mask_o, 0);
        check_eq("rst_empty", empty_o, 1);

        // Fill to capacity without commits
        for (int i = 0; i < 8; i++) step(1, 32'h100 + 32'(4*i), $urandom, 4'hF, 0, 0, 0, 32'h100);
        drive(1, 32'h120, 32'h0, 4'hF, 0, 0, 0, 32'h100);
        check_eq("fill_ready", push_ready_o, 0);
        check_eq("fill_drain_valid", drain_valid_o, 0);
        check_eq("fill_empty", empty_o, 0);
        tick();

        // Commit two then two, drain in order with backpressure on the third
        step(0, 0, 0, 0, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 2, 0, 1, 0);
        check_eq("drain0_addr", drain_addr_o, 32'h100);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("drain1_addr", drain_addr_o, 32'h104);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            check_eq("hold_addr", drain_addr_o, 32'h108);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("drain2_addr", drain_addr_o, 32'h108);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("drain3_addr", drain_addr_o, 32'h10C);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("drain_done_valid", drain_valid_o, 0);
        tick();

        // Flush: five pushed, two committed
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 32'h400 + 32'(4*i), $urandom, 4'hF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 2, 0, 0, 0);
        drive(1, 32'h500, 32'h5, 4'hF, 0, 1, 0, 0);
        check_eq("flush_push_blocked", push_ready_o, 0);
        tick();
        drive(1, 32'h600, 32'h66, 4'hF, 0, 0, 0, 32'h408);
        check_eq("flush_fwd_gone", fwd_mask_o, 0);
        check_eq("post_flush_ready", push_ready_o, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h600);
        check_eq("freed_slot_fwd", fwd_mask_o, 4'hF);
        check_eq("flush_drain0", drain_addr_o, 32'h400);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("flush_drain1", drain_addr_o, 32'h404);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("flush_no_third", drain_valid_o, 0);
        tick();
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // Forwarding merge
        do_reset();
        step(1, 32'h200, 32'hAABBCCDD, 4'b1111, 0, 0, 0, 0);
        step(1, 32'h202, 32'h11223344, 4'b0100, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h200);
        check_eq("fwd_merge_data", fwd_data_o, 32'hAA22CCDD);
        check_eq("fwd_merge_mask", fwd_mask_o, 4'b1111);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h300);
        check_eq("fwd_miss_mask", fwd_mask_o, 0);
        check_eq("fwd_miss_data", fwd_data_o, 0);
        tick();
        drive(1, 32'h200, 32'h55667788, 4'hF, 0, 0, 0, 32'h201);
        check_eq("fwd_same_cycle", fwd_data_o, 32'hAA22CCDD);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h203);
        check_eq("fwd_youngest", fwd_data_o, 32'h55667788);
        tick();

        // Over-commit saturates
        do_reset();
        step(1, 32'h700, 32'h7, 4'h3, 0, 0, 0, 0);
        step(1, 32'h704, 32'h8, 4'hC, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("ovc_valid", drain_valid_o, 1);
        check_eq("ovc_addr", drain_addr_o, 32'h700);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("ovc_not_past", drain_valid_o, 0);
        tick();
        step(0, 0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // Reset in the middle of draining
        for (int i = 0; i < 3; i++) step(1, 32'h800 + 32'(4*i), $urandom, 4'hF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 1, 0);
        check_eq("pre_rst_valid", drain_valid_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        mq.delete();
        mcmt = 0;
        @(negedge clk);
        rst = 1'b0;
        drain_ready_i = 1'b0;
        commit_num_i  = '0;
        #1;
        check_eq("mid_rst_empty", empty_o, 1);
        check_eq("mid_rst_valid", drain_valid_o, 0);

        // Random traffic across many pointer wraps
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 10) < 7,
                 32'h500 + 32'(4 * ($urandom % 4)) + 32'($urandom % 4),
                 $urandom, 4'($urandom % 16), int'($urandom % 3),
                 ($urandom % 20) == 0, ($urandom % 10) < 6,
                 32'h500 + 32'(4 * ($urandom % 5)) + 32'($urandom % 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
